// File: rtl/cnt_burst_ctrl.sv
// cnt_burst_ctrl: command-driven burst controller for a downstream max-counter.
// It accepts (period, repeat, prescale), drives the counter enable and max,
// counts carry-outs per burst, pulses done on completion, and on abort drains
// the counter back to zero before it pulses aborted.
// Optional build macro CNT_BURST_STAT_EN adds stat_bursts, a saturating
// 16-bit count of completed bursts.
module cnt_burst_ctrl #(
    parameter int DW = 8,
    parameter int RW = 4,
    parameter int PW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [DW-1:0] cmd_max,
    input  logic [RW-1:0] cmd_rep,
    input  logic [PW-1:0] cmd_div,
    input  logic          abort,
    output logic          cnt_en,
    output logic [DW-1:0] cnt_max,
    input  logic [DW-1:0] cnt_val,
    input  logic          cnt_co,
    output logic          busy,
    output logic          done,
    output logic          aborted,
    output logic [RW-1:0] rep_cnt
`ifdef CNT_BURST_STAT_EN
    ,
    output logic [15:0]   stat_bursts
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nx;

    logic [DW-1:0] max_q;
    logic [RW-1:0] rep_q;
    logic [PW-1:0] div_q;
    logic [PW-1:0] pre_q;
    logic [RW-1:0] rep_cnt_q;
    logic          aborted_q;

    logic          accept;
    logic          pre_wrap;
    logic          last_co;
    logic          drain_exit;

    assign accept     = cmd_valid && (state == IDLE);
    assign pre_wrap   = (pre_q == div_q);
    assign last_co    = cnt_co && (rep_cnt_q == rep_q);
    // Drain ends either when the counter is already at zero or on the carry
    // that wraps it back to zero.
    assign drain_exit = (cnt_val == '0) || cnt_co;

    assign cmd_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign cnt_max    = max_q;
    assign rep_cnt    = rep_cnt_q;
    assign aborted    = aborted_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode plus the enable and done outputs.
    always_comb begin
        state_nx = state;
        cnt_en   = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                cnt_en = pre_wrap;
                // A final carry wins over a same-cycle abort.
                if (last_co) begin
                    state_nx = DONE;
                end else if (abort) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                // Enable is withheld at zero so an idle counter is left untouched.
                cnt_en = (cnt_val != '0);
                if (drain_exit) begin
                    state_nx = IDLE;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Command latch, prescaler, period counter and the abort-complete pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            max_q     <= '0;
            rep_q     <= '0;
            div_q     <= '0;
            pre_q     <= '0;
            rep_cnt_q <= '0;
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= (state == DRAIN) && drain_exit;
            if (accept) begin
                max_q     <= cmd_max;
                rep_q     <= cmd_rep;
                div_q     <= cmd_div;
                pre_q     <= '0;
                rep_cnt_q <= '0;
            end else if (state == RUN) begin
                pre_q <= pre_wrap ? '0 : pre_q + PW'(1);
                if (cnt_co) begin
                    rep_cnt_q <= rep_cnt_q + RW'(1);
                end
            end
        end
    end

`ifdef CNT_BURST_STAT_EN
    logic [15:0] stat_q;

    // Saturating count of normally completed bursts.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_q <= '0;
        end else if ((state == DONE) && (stat_q != '1)) begin
            stat_q <= stat_q + 16'd1;
        end
    end

    assign stat_bursts = stat_q;
`endif

endmodule

// File: tb/tb_cnt_burst_ctrl.sv
// Testbench for cnt_burst_ctrl: a downstream max-counter stands in for the
// next stage, a timeline model predicts outputs every cycle, and directed
// scenarios add literal checks on latencies and counts.
module tb_cnt_burst_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_max;
    logic [3:0] cmd_rep;
    logic [3:0] cmd_div;
    logic       abort;
    logic       cnt_en;
    logic [7:0] cnt_max;
    logic [7:0] cnt;
    logic       cnt_co;
    logic       busy;
    logic       done;
    logic       aborted;
    logic [3:0] rep_cnt;
`ifdef CNT_BURST_STAT_EN
    logic [15:0] stat_bursts;
`endif

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    int t_acc;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    cnt_burst_ctrl #(.DW(8), .RW(4), .PW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_max   (cmd_max),
        .cmd_rep   (cmd_rep),
        .cmd_div   (cmd_div),
        .abort     (abort),
        .cnt_en    (cnt_en),
        .cnt_max   (cnt_max),
        .cnt_val   (cnt),
        .cnt_co    (cnt_co),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .rep_cnt   (rep_cnt)
`ifdef CNT_BURST_STAT_EN
        ,
        .stat_bursts (stat_bursts)
`endif
    );

    // Downstream max-counter; its active-low reset is ~rst.
    always @(posedge clk) begin
        if (rst) cnt <= 8'd0;
        else if (cnt_en) cnt <= (cnt == cnt_max) ? 8'd0 : cnt + 8'd1;
    end
    assign cnt_co = cnt_en && (cnt == cnt_max);

    task automatic chk(input string nm, input longint act, input longint exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- timeline model ----------------
    // A burst accepted in cycle T runs from t0=T+1; enable k falls at
    // t0+div+k*(div+1); N=(max+1)*(rep+1) enables; done sits at t0+N*(div+1).
    int m_in = 0, m_t0, m_tdone, m_mx = 0, m_r, m_div, m_n;
    int m_abc = -1, m_v, m_L, m_frz, m_abdone = -1, m_rep = 0, m_stat = 0;

    always @(negedge clk) begin
        int c, thr, e_rep, e_rdy, e_busy, e_en, e_done, e_ab;
        bit en_c;
        c = cyc;
        if (c >= 1) begin
            e_rdy = 1; e_busy = 0; e_en = 0; e_done = 0;
            e_ab = (c == m_abdone) ? 1 : 0;
            e_rep = m_rep;
            if (m_in != 0) begin
                e_rdy = 0; e_busy = 1; e_ab = 0;
                if (m_abc < 0 || c <= m_abc) begin
                    if (c < m_tdone) begin
                        e_en  = (((c - m_t0) % (m_div + 1)) == m_div) ? 1 : 0;
                        e_rep = (((c - m_t0) / (m_div + 1)) / (m_mx + 1)) % 16;
                    end else begin
                        e_done = 1;
                        e_rep  = (m_r + 1) % 16;
                    end
                end else begin
                    e_en  = (m_v != 0) ? 1 : 0;
                    e_rep = m_frz;
                end
            end
            chk("cmd_ready", cmd_ready, e_rdy);
            chk("busy", busy, e_busy);
            chk("cnt_en", cnt_en, e_en);
            chk("done", done, e_done);
            chk("aborted", aborted, e_ab);
            chk("rep_cnt", rep_cnt, e_rep);
            chk("cnt_max", cnt_max, m_mx);
`ifdef CNT_BURST_STAT_EN
            chk("stat_bursts", stat_bursts, m_stat);
`endif
        end
        // advance the model across the coming edge
        if (rst) begin
            m_in = 0; m_rep = 0; m_mx = 0; m_abdone = -1; m_stat = 0; m_abc = -1;
        end else if (m_in == 0) begin
            if (cmd_valid) begin
                m_in = 1; m_t0 = c + 1; m_mx = cmd_max; m_r = cmd_rep; m_div = cmd_div;
                m_abc = -1;
                m_n = (m_mx + 1) * (m_r + 1);
                m_tdone = m_t0 + m_n * (m_div + 1);
            end
        end else if (m_abc < 0) begin
            if (c == m_tdone) begin
                m_in = 0; m_rep = (m_r + 1) % 16;
                if (m_stat < 65535) m_stat++;
            end else if (abort) begin
                thr  = (c - m_t0 + 1) / (m_div + 1);
                en_c = ((c - m_t0) % (m_div + 1)) == m_div;
                if (!(en_c && thr == m_n)) begin
                    m_abc = c;
                    m_v   = thr % (m_mx + 1);
                    m_L   = (m_v == 0) ? 1 : m_mx + 1 - m_v;
                    m_frz = (thr / (m_mx + 1)) % 16;
                end
            end
        end else if (c == m_abc + m_L) begin
            m_in = 0; m_rep = m_frz; m_abdone = c + 1;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int m, input int r, input int d);
        cmd_valid = 1'b1;
        cmd_max   = 8'(m);
        cmd_rep   = 4'(r);
        cmd_div   = 4'(d);
        step();
        cmd_valid = 1'b0;
        t_acc     = cyc - 1;
    endtask

    // Wait for done or aborted; report its cycle offset from the accept cycle.
    task automatic wait_end(output int off, output int ens, output int was_done, output int rc);
        bit hit = 1'b0;
        off = -1; ens = 0; was_done = 0; rc = -1;
        for (int i = 0; i < 3000 && !hit; i++) begin
            @(negedge clk);
            if (cnt_en) ens++;
            if (done || aborted) begin
                off = cyc - t_acc; was_done = done ? 1 : 0; rc = rep_cnt; hit = 1'b1;
            end
        end
        if (!hit) chk("end_timeout", 0, 1);
        step();
    endtask

    task automatic wait_cnt(input int v);
        bit hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            step();
            if (cnt == 8'(v)) hit = 1'b1;
        end
        if (!hit) chk("cnt_timeout", 0, 1);
    endtask

    initial begin
        int off, ens, wd, rc;
        rst = 1'b1; cmd_valid = 1'b0; cmd_max = '0; cmd_rep = '0; cmd_div = '0; abort = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_max", cnt_max, 0);
        step();

        // basic burst
        send(3, 1, 0);
        wait_end(off, ens, wd, rc);
        chk("basic_done_off", off, 9);
        chk("basic_ens", ens, 8);
        chk("basic_repcnt", rc, 2);
        chk("basic_isdone", wd, 1);
        @(negedge clk);
        chk("basic_ready_after", cmd_ready, 1);
        step();

        // prescale
        send(1, 0, 2);
        wait_end(off, ens, wd, rc);
        chk("pre_done_off", off, 7);
        chk("pre_ens", ens, 2);

        // abort mid-period
        send(9, 0, 0);
        wait_cnt(4);
        abort = 1'b1;
        wait_end(off, ens, wd, rc);
        abort = 1'b0;
        chk("abmid_off", off, 11);
        chk("abmid_ens", ens, 6);
        chk("abmid_notdone", wd, 0);
        chk("abmid_cnt0", cnt, 0);

        // abort before any enable
        abort = 1'b1;
        send(5, 2, 3);
        wait_end(off, ens, wd, rc);
        abort = 1'b0;
        chk("ab0_off", off, 3);
        chk("ab0_ens", ens, 0);
        chk("ab0_notdone", wd, 0);
        chk("ab0_cnt0", cnt, 0);

        // abort coincident with final carry
        send(2, 0, 0);
        wait_cnt(2);
        abort = 1'b1;
        wait_end(off, ens, wd, rc);
        abort = 1'b0;
        chk("abco_off", off, 4);
        chk("abco_isdone", wd, 1);
        @(negedge clk);
        chk("abco_no_aborted", aborted, 0);
        step();

        // rep count wraps at full scale
        send(0, 15, 0);
        wait_end(off, ens, wd, rc);
        chk("wrap_off", off, 17);
        chk("wrap_ens", ens, 16);
        chk("wrap_repcnt", rc, 0);

        // smallest burst
        send(0, 0, 0);
        wait_end(off, ens, wd, rc);
        chk("min_off", off, 2);
        chk("min_repcnt", rc, 1);

        // back-pressure then reset mid-run
        send(7, 0, 1);
        cmd_valid = 1'b1; cmd_max = 8'd200;
        repeat (4) begin
            @(negedge clk);
            chk("bp_ready", cmd_ready, 0);
            chk("bp_max", cnt_max, 7);
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0; cmd_valid = 1'b0;
        @(negedge clk);
        chk("mrst_busy", busy, 0);
        chk("mrst_en", cnt_en, 0);
        chk("mrst_rep", rep_cnt, 0);
        chk("mrst_max", cnt_max, 0);
        chk("mrst_ready", cmd_ready, 1);
        step();

        // three bursts after the reset
        for (int i = 0; i < 3; i++) begin
            send(1, 1, 1);
            wait_end(off, ens, wd, rc);
            chk("tri_off", off, 9);
        end
`ifdef CNT_BURST_STAT_EN
        @(negedge clk);
        chk("stat3", stat_bursts, 3);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("stat_rst", stat_bursts, 0);
        step();
`endif
        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
